pkt_inj_enc: RTL and testbench
==============================

PKT_INJ_ENC -- requirements
Module: pkt_inj_enc

Interface
REQ-001 Parameter MY_XPOS, default 0, source-node X coordinate (0..4).
REQ-002 Parameter MY_YPOS, default 0, source-node Y coordinate (0..3); MY_POS = MY_XPOS*4+MY_YPOS.
REQ-003 Parameter PKTLEN, default 4, flits per packet including head (legal range 2..16).
REQ-004 Port clk, input, 1, single clock; all logic is on its rising edge.
REQ-005 Port rst, input, 1, synchronous, active-high reset.
REQ-006 Port req_valid / req_ready, input / output, 1 / 1, packet-request handshake.
REQ-007 Port req_dst, input, 20, destination bitmask; bit n = node n (n = x*4+y).
REQ-008 Port pay_valid / pay_ready, input / output, 1 / 1, payload-word handshake.
REQ-009 Port pay_data, input, 32, payload word.
REQ-010 Port out_valid / out_ready, output / input, 1 / 1, flit handshake toward the router.
REQ-011 Port out_ftype, output, 2, flit type: 01 = head, 10 = body, 11 = tail.
REQ-012 Port out_um, output, 1, 0 = unicast, 1 = multicast (head flit only, else 0).
REQ-013 Port out_addr0, output, 5, binary unicast destination (head flit only, else 0).
REQ-014 Port out_addr1, output, 20, one-hot multicast mask (head flit only, else 0).
REQ-015 Port out_data, output, 32, payload (body/tail flits; 0 on head).
REQ-016 Port err_drop, output, 1, one-cycle pulse when a request is dropped.
REQ-017 Port pkt_cnt, output, 16, count of completed packets (tail accepted), wraps.

Function
REQ-018 FSM states: IDLE, HEAD, BODY; reset state IDLE.
REQ-019 req_ready is 1 only in IDLE; a request is accepted on req_valid&req_ready.
REQ-020 On acceptance, masked = req_dst with bit MY_POS cleared.
REQ-021 If masked == 0: no flits emitted, err_drop pulses the following cycle, FSM stays IDLE.
REQ-022 If popcount(masked) == 1: head is unicast, out_um = 0, out_addr0 = index of the set bit, out_addr1 = 0.
REQ-023 If popcount(masked) >= 2: head is multicast, out_um = 1, out_addr1 = masked, out_addr0 = 0.
REQ-024 Head flit appears with out_valid = 1 exactly one cycle after request acceptance (state HEAD).
REQ-025 All out_* fields are held stable while out_valid & !out_ready.
REQ-026 Head handshake moves FSM to BODY with flit counter = 1.
REQ-027 In BODY, pay_ready = (!out_valid | out_ready); an accepted payload word is registered onto out_data with out_valid = 1 the next cycle.
REQ-028 A body flit carries out_ftype 10, except the flit whose counter reaches PKTLEN-1, which is tagged 11 (tail).
REQ-029 On tail handshake: pkt_cnt increments (wraps 0xFFFF -> 0), and FSM returns to IDLE; the next request is accepted no earlier than the following cycle.
REQ-030 When the output register is empty and no payload is valid, out_valid = 0 (bubbles allowed; no timeout).
REQ-031 When a flit handshake and a new payload acceptance occur in the same cycle, the output register is overwritten without a bubble (full throughput: 1 flit per cycle).

Reset
REQ-032 On rst = 1 at a clock edge: FSM = IDLE; out_valid = 0; all out_* fields = 0; err_drop = 0; pkt_cnt = 0; flit counter = 0; req_ready = 0 during reset and 1 the cycle after.
REQ-033 Reset mid-packet discards the partial packet; no tail is emitted and pkt_cnt is not incremented.

Structure
REQ-034 Flit-type codes, the UADDR/MADDR widths (5/20), and the node count (20) reside in the shared define header used by the routers.
REQ-035 A combinational sub-module mask_enc (20-bit mask -> {is_zero, is_single, 5-bit index}) is instantiated once; everything else is in pkt_inj_enc.

Verification (MY_XPOS=1, MY_YPOS=2, MY_POS=6, PKTLEN=4)
REQ-036 req_dst = 0x02000, out_ready = 1 -> head um=0, addr0=13; then 2 body flits and 1 tail flit carrying pay_data in order; pkt_cnt = 1.
REQ-037 req_dst = 0x00A01 -> head um=1, addr1=0x00A01, addr0=0; 4 flits total.
REQ-038 req_dst = 0x00040 (self only) -> no out_valid; err_drop high for 1 cycle; pkt_cnt unchanged.
REQ-039 req_dst = 0x00041 -> self bit stripped; unicast head with addr0=0.
REQ-040 out_ready low for 3 cycles during a body flit -> flit fields remain constant, pay_ready = 0, no payload is lost or duplicated.
REQ-041 rst asserted after the head handshake -> out_valid = 0 next cycle, pkt_cnt = 0, next request is serviced normally.

Source files
------------

// File: rtl/pkt_inj_enc_pkg.sv
// pkt_inj_enc_pkg: flit type codes, address widths, node count and FSM states shared with the routers
package pkt_inj_enc_pkg;
    localparam int NODES   = 20;
    localparam int UADDR_W = 5;
    localparam int MADDR_W = 20;
    typedef enum logic [1:0] {FT_NONE = 2'b00, FT_HEAD = 2'b01, FT_BODY = 2'b10, FT_TAIL = 2'b11} ftype_e;
    typedef enum logic [1:0] {IDLE, HEAD, BODY} state_e;
endpackage

// File: rtl/pkt_inj_enc_mask.sv
// mask_enc: classifies a destination mask as empty, single-node or multi-node and encodes its set bit
module mask_enc
    import pkt_inj_enc_pkg::*;
(
    input  logic [MADDR_W-1:0] mask,
    output logic               is_zero,
    output logic               is_single,
    output logic [UADDR_W-1:0] idx
);
    assign is_zero   = mask == '0;
    assign is_single = !is_zero && ((mask & (mask - MADDR_W'(1))) == '0);
    always_comb begin
        idx = '0;
        for (int i = 0; i < NODES; i++) if (mask[i]) idx = UADDR_W'(i);
    end
endmodule

// File: rtl/pkt_inj_enc.sv
// pkt_inj_enc: turns destination requests plus payload words into head/body/tail flits for the router
module pkt_inj_enc
    import pkt_inj_enc_pkg::*;
#(
    parameter int MY_XPOS = 0,
    parameter int MY_YPOS = 0,
    parameter int PKTLEN  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [MADDR_W-1:0] req_dst,
    input  logic               pay_valid,
    output logic               pay_ready,
    input  logic [31:0]        pay_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [1:0]         out_ftype,
    output logic               out_um,
    output logic [UADDR_W-1:0] out_addr0,
    output logic [MADDR_W-1:0] out_addr1,
    output logic [31:0]        out_data,
    output logic               err_drop,
    output logic [15:0]        pkt_cnt
);
    localparam int MY_POS = MY_XPOS * 4 + MY_YPOS;
    localparam int CW     = $clog2(PKTLEN + 1);

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                out_valid_q, out_valid_d;
    ftype_e              out_ftype_q, out_ftype_d;
    logic                out_um_q, out_um_d;
    logic [UADDR_W-1:0]  out_addr0_q, out_addr0_d;
    logic [MADDR_W-1:0]  out_addr1_q, out_addr1_d;
    logic [31:0]         out_data_q, out_data_d;
    logic                err_drop_q, err_drop_d;
    logic [15:0]         pkt_cnt_q, pkt_cnt_d;
    logic [MADDR_W-1:0]  masked;
    logic                is_zero, is_single;
    logic [UADDR_W-1:0]  idx;

    assign masked = req_dst & ~(MADDR_W'(1) << MY_POS);

    mask_enc u_mask_enc (.mask(masked), .is_zero(is_zero), .is_single(is_single), .idx(idx));

    assign req_ready = !rst && state_q == IDLE;
    // once the tail is loaded the counter sits at PKTLEN and further payload is refused
    assign pay_ready = !rst && state_q == BODY && cnt_q != CW'(PKTLEN) && (!out_valid_q || out_ready);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_ftype_d = out_ftype_q;
        out_um_d    = out_um_q;
        out_addr0_d = out_addr0_q;
        out_addr1_d = out_addr1_q;
        out_data_d  = out_data_q;
        err_drop_d  = 1'b0;
        pkt_cnt_d   = pkt_cnt_q;
        unique case (state_q)
            IDLE: if (req_valid && req_ready) begin
                if (is_zero) begin
                    err_drop_d = 1'b1;
                end else begin
                    state_d     = HEAD;
                    out_valid_d = 1'b1;
                    out_ftype_d = FT_HEAD;
                    out_um_d    = !is_single;
                    out_addr0_d = is_single ? idx : '0;
                    out_addr1_d = is_single ? '0 : masked;
                    out_data_d  = '0;
                end
            end
            HEAD: if (out_ready) begin
                state_d     = BODY;
                cnt_d       = CW'(1);
                out_valid_d = 1'b0;
                out_ftype_d = FT_NONE;
                out_um_d    = 1'b0;
                out_addr0_d = '0;
                out_addr1_d = '0;
            end
            BODY: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    out_ftype_d = FT_NONE;
                    out_data_d  = '0;
                    if (out_ftype_q == FT_TAIL) begin
                        state_d   = IDLE;
                        cnt_d     = '0;
                        pkt_cnt_d = pkt_cnt_q + 16'd1;
                    end
                end
                if (pay_valid && pay_ready) begin
                    out_valid_d = 1'b1;
                    out_ftype_d = cnt_q == CW'(PKTLEN - 1) ? FT_TAIL : FT_BODY;
                    out_data_d  = pay_data;
                    cnt_d       = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_ftype_q <= FT_NONE;
            out_um_q    <= 1'b0;
            out_addr0_q <= '0;
            out_addr1_q <= '0;
            out_data_q  <= '0;
            err_drop_q  <= 1'b0;
            pkt_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_ftype_q <= out_ftype_d;
            out_um_q    <= out_um_d;
            out_addr0_q <= out_addr0_d;
            out_addr1_q <= out_addr1_d;
            out_data_q  <= out_data_d;
            err_drop_q  <= err_drop_d;
            pkt_cnt_q   <= pkt_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_ftype = out_ftype_q;
    assign out_um    = out_um_q;
    assign out_addr0 = out_addr0_q;
    assign out_addr1 = out_addr1_q;
    assign out_data  = out_data_q;
    assign err_drop  = err_drop_q;
    assign pkt_cnt   = pkt_cnt_q;
endmodule

// File: tb/tb_pkt_inj_enc.sv
// tb_pkt_inj_enc: directed scenarios for pkt_inj_enc at node (1,2) with 4-flit packets
module tb_pkt_inj_enc;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_ready;
    logic [19:0] req_dst = '0;
    logic        pay_valid = 1'b0, pay_ready;
    logic [31:0] pay_data = '0;
    logic        out_valid, out_ready = 1'b1;
    logic [1:0]  out_ftype;
    logic        out_um;
    logic [4:0]  out_addr0;
    logic [19:0] out_addr1;
    logic [31:0] out_data;
    logic        err_drop;
    logic [15:0] pkt_cnt;
    int          checks = 0, errors = 0, drops = 0, cyc_n = 0;
    logic [59:0] mon_q[$];
    int          mon_t[$];

    pkt_inj_enc #(.MY_XPOS(1), .MY_YPOS(2), .PKTLEN(4)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_dst(req_dst),
        .pay_valid(pay_valid), .pay_ready(pay_ready), .pay_data(pay_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ftype(out_ftype), .out_um(out_um),
        .out_addr0(out_addr0), .out_addr1(out_addr1), .out_data(out_data),
        .err_drop(err_drop), .pkt_cnt(pkt_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    // record every flit that will be handshaken on the coming edge
    always @(negedge clk) if (!rst) begin
        if (out_valid && out_ready) begin
            mon_q.push_back({out_ftype, out_um, out_addr0, out_addr1, out_data});
            mon_t.push_back(cyc_n);
        end
        if (err_drop) drops++;
    end

    function automatic logic [59:0] fl(input logic [1:0] ft, input logic um, input logic [4:0] a0,
                                       input logic [19:0] a1, input logic [31:0] d);
        return {ft, um, a0, a1, d};
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send_req(input logic [19:0] dst);
        int k = 0;
        req_valid = 1'b1; req_dst = dst; #1;
        while (!req_ready && k < 50) begin @(posedge clk); #2; k++; end
        checks++;
        if (k >= 50) begin errors++; $display("FAIL req_timeout dst=%h", dst); end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic feed(input logic [31:0] base, input int n);
        int k;
        for (int i = 0; i < n; i++) begin
            k = 0;
            pay_valid = 1'b1; pay_data = base + 32'(i); #1;
            while (!pay_ready && k < 50) begin @(posedge clk); #2; k++; end
            checks++;
            if (k >= 50) begin errors++; $display("FAIL pay_timeout word=%0d", i); end
            @(posedge clk); #1;
        end
        pay_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) tick();
        #1;
        checks += 5;
        if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready got=%b exp=0", req_ready); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        if (pkt_cnt !== 16'd0) begin errors++; $display("FAIL rst_pkt_cnt got=%0d exp=0", pkt_cnt); end
        if (err_drop !== 1'b0) begin errors++; $display("FAIL rst_err_drop got=%b exp=0", err_drop); end
        if ({out_ftype, out_um, out_addr0, out_addr1, out_data} !== 60'd0)
            begin errors++; $display("FAIL rst_fields got=%h exp=0", {out_ftype, out_um, out_addr0, out_addr1, out_data}); end
        rst = 1'b0; #1;
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_release_req_ready got=%b exp=1", req_ready); end
    endtask

    task automatic test_unicast();
        logic [59:0] exp[4];
        exp = '{fl(2'b01, 1'b0, 5'd13, 20'h0, 32'h0), fl(2'b10, 1'b0, 5'd0, 20'h0, 32'h1000),
                fl(2'b10, 1'b0, 5'd0, 20'h0, 32'h1001), fl(2'b11, 1'b0, 5'd0, 20'h0, 32'h1002)};
        mon_q.delete(); out_ready = 1'b1;
        send_req(20'h02000);
        #1;
        checks += 2;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL uni_head_latency got=%b exp=1", out_valid); end
        if (req_ready !== 1'b0) begin errors++; $display("FAIL uni_req_ready_busy got=%b exp=0", req_ready); end
        feed(32'h1000, 3);
        repeat (3) tick();
        checks++;
        if (mon_q.size() != 4) begin errors++; $display("FAIL uni_count got=%0d exp=4", mon_q.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mon_q.size() <= i || mon_q[i] !== exp[i]) begin
                errors++; $display("FAIL uni_flit%0d got=%h exp=%h", i, mon_q.size() > i ? mon_q[i] : 60'hx, exp[i]);
            end
        end
        checks++;
        if (pkt_cnt !== 16'd1) begin errors++; $display("FAIL uni_pkt_cnt got=%0d exp=1", pkt_cnt); end
    endtask

    task automatic test_multicast();
        logic [59:0] exp[4];
        exp = '{fl(2'b01, 1'b1, 5'd0, 20'h00A01, 32'h0), fl(2'b10, 1'b0, 5'd0, 20'h0, 32'h2000),
                fl(2'b10, 1'b0, 5'd0, 20'h0, 32'h2001), fl(2'b11, 1'b0, 5'd0, 20'h0, 32'h2002)};
        mon_q.delete();
        send_req(20'h00A01);
        feed(32'h2000, 3);
        repeat (3) tick();
        checks++;
        if (mon_q.size() != 4) begin errors++; $display("FAIL mc_count got=%0d exp=4", mon_q.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mon_q.size() <= i || mon_q[i] !== exp[i]) begin
                errors++; $display("FAIL mc_flit%0d got=%h exp=%h", i, mon_q.size() > i ? mon_q[i] : 60'hx, exp[i]);
            end
        end
        checks++;
        if (pkt_cnt !== 16'd2) begin errors++; $display("FAIL mc_pkt_cnt got=%0d exp=2", pkt_cnt); end
    endtask

    task automatic test_self_drop();
        mon_q.delete(); drops = 0;
        send_req(20'h00040);
        #1;
        checks++;
        if (err_drop !== 1'b1) begin errors++; $display("FAIL drop_pulse got=%b exp=1", err_drop); end
        repeat (4) tick();
        checks += 4;
        if (drops != 1) begin errors++; $display("FAIL drop_width got=%0d exp=1", drops); end
        if (mon_q.size() != 0) begin errors++; $display("FAIL drop_flits got=%0d exp=0", mon_q.size()); end
        if (pkt_cnt !== 16'd2) begin errors++; $display("FAIL drop_pkt_cnt got=%0d exp=2", pkt_cnt); end
        if (req_ready !== 1'b1) begin errors++; $display("FAIL drop_idle got=%b exp=1", req_ready); end
    endtask

    task automatic test_self_strip();
        mon_q.delete();
        send_req(20'h00041);
        feed(32'h3000, 3);
        repeat (3) tick();
        checks += 3;
        if (mon_q.size() != 4) begin errors++; $display("FAIL strip_count got=%0d exp=4", mon_q.size()); end
        if (mon_q.size() < 1 || mon_q[0] !== fl(2'b01, 1'b0, 5'd0, 20'h0, 32'h0))
            begin errors++; $display("FAIL strip_head got=%h exp=%h", mon_q.size() > 0 ? mon_q[0] : 60'hx, fl(2'b01, 1'b0, 5'd0, 20'h0, 32'h0)); end
        if (pkt_cnt !== 16'd3) begin errors++; $display("FAIL strip_pkt_cnt got=%0d exp=3", pkt_cnt); end
    endtask

    task automatic test_backpressure();
        logic [59:0] exp[4];
        exp = '{fl(2'b01, 1'b0, 5'd13, 20'h0, 32'h0), fl(2'b10, 1'b0, 5'd0, 20'h0, 32'h4000),
                fl(2'b10, 1'b0, 5'd0, 20'h0, 32'h4001), fl(2'b11, 1'b0, 5'd0, 20'h0, 32'h4002)};
        mon_q.delete(); out_ready = 1'b1;
        send_req(20'h02000);
        pay_valid = 1'b1; pay_data = 32'h4000;
        tick();
        tick();
        out_ready = 1'b0; pay_data = 32'h4001; #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({out_valid, out_ftype, out_data, pay_ready} !== {1'b1, 2'b10, 32'h4000, 1'b0})
                begin errors++; $display("FAIL bp_hold%0d got=%h exp=%h", i, {out_valid, out_ftype, out_data, pay_ready}, {1'b1, 2'b10, 32'h4000, 1'b0}); end
            tick(); #1;
        end
        out_ready = 1'b1;
        feed(32'h4001, 2);
        repeat (3) tick();
        checks++;
        if (mon_q.size() != 4) begin errors++; $display("FAIL bp_count got=%0d exp=4", mon_q.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mon_q.size() <= i || mon_q[i] !== exp[i]) begin
                errors++; $display("FAIL bp_flit%0d got=%h exp=%h", i, mon_q.size() > i ? mon_q[i] : 60'hx, exp[i]);
            end
        end
        checks++;
        if (pkt_cnt !== 16'd4) begin errors++; $display("FAIL bp_pkt_cnt got=%0d exp=4", pkt_cnt); end
    endtask

    task automatic test_mid_reset();
        mon_q.delete(); out_ready = 1'b1;
        send_req(20'h00100);
        tick();
        rst = 1'b1; pay_valid = 1'b1; pay_data = 32'hDEAD;
        tick(); #1;
        checks += 3;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL mr_out_valid got=%b exp=0", out_valid); end
        if (pkt_cnt !== 16'd0) begin errors++; $display("FAIL mr_pkt_cnt got=%0d exp=0", pkt_cnt); end
        if (req_ready !== 1'b0) begin errors++; $display("FAIL mr_req_ready got=%b exp=0", req_ready); end
        pay_valid = 1'b0; rst = 1'b0; #1;
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL mr_release got=%b exp=1", req_ready); end
        mon_q.delete();
        send_req(20'h00008);
        feed(32'h5000, 3);
        repeat (3) tick();
        checks += 3;
        if (mon_q.size() != 4) begin errors++; $display("FAIL mr_count got=%0d exp=4", mon_q.size()); end
        if (mon_q.size() < 4 || mon_q[0] !== fl(2'b01, 1'b0, 5'd3, 20'h0, 32'h0) || mon_q[3] !== fl(2'b11, 1'b0, 5'd0, 20'h0, 32'h5002))
            begin errors++; $display("FAIL mr_packet got=%h/%h exp=%h/%h", mon_q.size() > 0 ? mon_q[0] : 60'hx, mon_q.size() > 3 ? mon_q[3] : 60'hx, fl(2'b01, 1'b0, 5'd3, 20'h0, 32'h0), fl(2'b11, 1'b0, 5'd0, 20'h0, 32'h5002)); end
        if (pkt_cnt !== 16'd1) begin errors++; $display("FAIL mr_pkt_cnt_after got=%0d exp=1", pkt_cnt); end
    endtask

    task automatic test_back_to_back();
        mon_q.delete(); mon_t.delete(); out_ready = 1'b1;
        send_req(20'h80000);
        feed(32'h6000, 3);
        send_req(20'h00030);
        feed(32'h7000, 3);
        repeat (3) tick();
        checks++;
        if (mon_q.size() != 8) begin errors++; $display("FAIL b2b_count got=%0d exp=8", mon_q.size()); end
        if (mon_q.size() == 8) begin
            checks += 5;
            if (mon_q[0] !== fl(2'b01, 1'b0, 5'd19, 20'h0, 32'h0))
                begin errors++; $display("FAIL b2b_head0 got=%h exp=%h", mon_q[0], fl(2'b01, 1'b0, 5'd19, 20'h0, 32'h0)); end
            if (mon_q[4] !== fl(2'b01, 1'b1, 5'd0, 20'h00030, 32'h0))
                begin errors++; $display("FAIL b2b_head1 got=%h exp=%h", mon_q[4], fl(2'b01, 1'b1, 5'd0, 20'h00030, 32'h0)); end
            if (mon_q[7] !== fl(2'b11, 1'b0, 5'd0, 20'h0, 32'h7002))
                begin errors++; $display("FAIL b2b_tail1 got=%h exp=%h", mon_q[7], fl(2'b11, 1'b0, 5'd0, 20'h0, 32'h7002)); end
            if (mon_t[3] - mon_t[1] != 2) begin errors++; $display("FAIL b2b_gap0 got=%0d exp=2", mon_t[3] - mon_t[1]); end
            if (mon_t[7] - mon_t[5] != 2) begin errors++; $display("FAIL b2b_gap1 got=%0d exp=2", mon_t[7] - mon_t[5]); end
        end
        checks++;
        if (pkt_cnt !== 16'd3) begin errors++; $display("FAIL b2b_pkt_cnt got=%0d exp=3", pkt_cnt); end
    endtask

    initial begin
        test_reset();
        test_unicast();
        test_multicast();
        test_self_drop();
        test_self_strip();
        test_backpressure();
        test_mid_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
